// File: rtl/mw_stage_reg.sv
// Execute-to-memory/writeback stage register with valid/ready, flush
// and stall counter. Define MW_SKID_EN for the 2-entry skid variant.
module mw_stage_reg #(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [RA_W-1:0]  waddr,
  input  logic [XLEN-1:0]  AddrF,
  input  logic [XLEN-1:0]  ALUResult,
  input  logic [XLEN-1:0]  SrcBE,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RA_W-1:0]  waddr_MW,
  output logic [XLEN-1:0]  Addr_MW,
  output logic [XLEN-1:0]  ALUResult_MW,
  output logic [XLEN-1:0]  rdata2_MW,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int DW = RA_W + 3 * XLEN;

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;

  logic [1:0]       r_state;
  logic [1:0]       w_next;
  logic [DW-1:0]    r_main;
  logic [DW-1:0]    w_in;
  logic             w_acc;
  logic             w_del;
  logic             w_ld_in;
  logic [CNT_W-1:0] r_cnt;

  assign w_in      = {waddr, AddrF, ALUResult, SrcBE};
  assign out_valid = (r_state != S_EMPTY);
  assign w_acc     = in_valid && in_ready;
  assign w_del     = out_valid && out_ready;
  assign stall_cnt = r_cnt;

  assign {waddr_MW, Addr_MW, ALUResult_MW, rdata2_MW} = r_main;

`ifdef MW_SKID_EN

  localparam logic [1:0] S_TWO = 2'd2;

  logic [DW-1:0] r_skid;
  logic          r_rdy;
  logic          w_ld_skid;
  logic          w_sk2main;

  // Ready comes from a flop; reset only masks it.
  assign in_ready = rst && r_rdy;

  // Next state and load selects for main/skid slots.
  always_comb begin
    w_next    = r_state;
    w_ld_in   = 1'b0;
    w_ld_skid = 1'b0;
    w_sk2main = 1'b0;
    unique case (r_state)
      S_EMPTY: begin
        if (w_acc) begin
          w_next  = S_ONE;
          w_ld_in = 1'b1;
        end
      end
      S_ONE: begin
        if (w_acc && w_del) begin
          w_ld_in = 1'b1;
        end else if (w_acc) begin
          w_next    = S_TWO;
          w_ld_skid = 1'b1;
        end else if (w_del) begin
          w_next = S_EMPTY;
        end
      end
      S_TWO: begin
        if (w_del) begin
          w_next    = S_ONE;
          w_sk2main = 1'b1;
        end
      end
      default: w_next = S_EMPTY;
    endcase
    if (flush) begin
      w_next    = S_EMPTY;
      w_ld_in   = 1'b0;
      w_ld_skid = 1'b0;
      w_sk2main = 1'b0;
    end
  end

  // State, registered ready and the two data slots.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_EMPTY;
      r_rdy   <= 1'b1;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_next;
      r_rdy   <= (w_next != S_TWO);
      if (w_ld_in) begin
        r_main <= w_in;
      end else if (w_sk2main) begin
        r_main <= r_skid;
      end
      if (w_ld_skid) begin
        r_skid <= w_in;
      end
    end
  end

`else

  // Single slot: ready follows the downstream combinationally.
  assign in_ready = rst && (!out_valid || out_ready);

  // Next state and main-slot load select.
  always_comb begin
    w_next  = r_state;
    w_ld_in = 1'b0;
    if (w_acc) begin
      w_next  = S_ONE;
      w_ld_in = 1'b1;
    end else if (w_del) begin
      w_next = S_EMPTY;
    end
    if (flush) begin
      w_next  = S_EMPTY;
      w_ld_in = 1'b0;
    end
  end

  // State and main data slot.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_EMPTY;
      r_main  <= '0;
    end else begin
      r_state <= w_next;
      if (w_ld_in) begin
        r_main <= w_in;
      end
    end
  end

`endif

  // Saturating count of back-pressured cycles; flush leaves it alone.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (out_valid && !out_ready &&
                 (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mw_stage_reg.sv
// Randomized bench for mw_stage_reg against a queue-based model.
// Honours MW_SKID_EN to pick the expected buffering depth.
module tb_mw_stage_reg;

  localparam int XLEN  = 32;
  localparam int RA_W  = 5;
  localparam int CNT_W = 3;

`ifdef MW_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [RA_W-1:0]  waddr = '0;
  logic [XLEN-1:0]  AddrF = '0;
  logic [XLEN-1:0]  ALUResult = '0;
  logic [XLEN-1:0]  SrcBE = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [RA_W-1:0]  waddr_MW;
  logic [XLEN-1:0]  Addr_MW;
  logic [XLEN-1:0]  ALUResult_MW;
  logic [XLEN-1:0]  rdata2_MW;
  logic [CNT_W-1:0] stall_cnt;

  always #5 clk = ~clk;

  mw_stage_reg #(
    .XLEN (XLEN),
    .RA_W (RA_W),
    .CNT_W(CNT_W)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .waddr       (waddr),
    .AddrF       (AddrF),
    .ALUResult   (ALUResult),
    .SrcBE       (SrcBE),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .waddr_MW    (waddr_MW),
    .Addr_MW     (Addr_MW),
    .ALUResult_MW(ALUResult_MW),
    .rdata2_MW   (rdata2_MW),
    .stall_cnt   (stall_cnt)
  );

  typedef struct {
    logic [RA_W-1:0] wa;
    logic [XLEN-1:0] ad;
    logic [XLEN-1:0] al;
    logic [XLEN-1:0] sd;
  } ent_t;

  ent_t q[$];
  int   m_cnt  = 0;
  bit   m_zero = 1'b1;
  int   n_chk  = 0;
  int   n_err  = 0;
  int   n_acc  = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit m_rdy();
    if (!rst) return 1'b0;
    if (SKID) return q.size() < 2;
    return (q.size() == 0) || out_ready;
  endfunction

  task automatic check_outs();
    chk("in_ready", in_ready, m_rdy());
    chk("out_valid", out_valid, q.size() != 0);
    chk("stall_cnt", stall_cnt, m_cnt);
    if (q.size() != 0) begin
      chk("waddr_MW", waddr_MW, q[0].wa);
      chk("Addr_MW", Addr_MW, q[0].ad);
      chk("ALUResult_MW", ALUResult_MW, q[0].al);
      chk("rdata2_MW", rdata2_MW, q[0].sd);
    end else if (m_zero) begin
      chk("waddr_MW_rst", waddr_MW, 0);
      chk("Addr_MW_rst", Addr_MW, 0);
      chk("ALUResult_MW_rst", ALUResult_MW, 0);
      chk("rdata2_MW_rst", rdata2_MW, 0);
    end
  endtask

  task automatic model_edge();
    bit   acc;
    bit   del;
    ent_t e;
    acc = in_valid && m_rdy();
    del = (q.size() != 0) && out_ready;
    e.wa = waddr;
    e.ad = AddrF;
    e.al = ALUResult;
    e.sd = SrcBE;
    if (!rst) begin
      q.delete();
      m_cnt  = 0;
      m_zero = 1'b1;
    end else begin
      if (q.size() != 0 && !out_ready &&
          m_cnt < (1 << CNT_W) - 1)
        m_cnt++;
      if (flush) begin
        q.delete();
      end else begin
        if (del) void'(q.pop_front());
        if (acc) begin
          q.push_back(e);
          m_zero = 1'b0;
        end
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outs();
    if (in_valid && in_ready) n_acc++;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic rnd_data();
    waddr     = RA_W'($urandom);
    AddrF     = $urandom;
    ALUResult = $urandom;
    SrcBE     = $urandom;
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    rnd_data();
    @(posedge clk);
    model_edge();
    #1;
    repeat (3) begin
      rnd_data();
      cycle();
    end

    rst      = 1'b1;
    in_valid = 1'b0;
    cycle();

    for (int i = 0; i < 8; i++) begin
      in_valid  = 1'b1;
      out_ready = 1'b1;
      rnd_data();
      AddrF     = 32'h100 + 32'(4 * i);
      ALUResult = 32'(i);
      cycle();
    end
    in_valid = 1'b0;
    repeat (2) cycle();

    n_acc     = 0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    repeat (4) begin
      rnd_data();
      cycle();
    end
    chk("bp_accepts", n_acc, SKID ? 2 : 1);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    repeat (3) cycle();

    out_ready = 1'b0;
    in_valid  = 1'b1;
    repeat (2) begin
      rnd_data();
      cycle();
    end
    flush = 1'b1;
    rnd_data();
    cycle();
    flush    = 1'b0;
    in_valid = 1'b0;
    cycle();
    chk("flush_ovalid", out_valid, 0);
    chk("flush_iready", in_ready, 1);

    in_valid = 1'b1;
    rnd_data();
    cycle();
    in_valid = 1'b0;
    repeat (10) cycle();
    chk("sat_cnt", stall_cnt, 7);

    in_valid = 1'b1;
    repeat (2) begin
      rnd_data();
      cycle();
    end
    rst = 1'b0;
    cycle();
    rst      = 1'b1;
    in_valid = 1'b0;
    cycle();
    chk("mid_rst_cnt", stall_cnt, 0);

    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom % 50) != 0;
      flush     = ($urandom % 12) == 0;
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      rnd_data();
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
